bram_port_arbiter: RTL



---
 rtl/bram_port_arbiter_if.sv | 39 +++
 rtl/bram_port_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/bram_port_arbiter_if.sv
// Bus bundle between the core (fetch + load/store requesters), the arbiter and bram_sdp.
// Handshake: req and its payload are held until gnt, and the transfer is accepted in the
// cycle where gnt is 1. A req dropped before gnt is never serviced. rvalid is a one-cycle
// strobe with no back-pressure, and rdata is zero whenever rvalid is low.
interface bram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 7
);
    logic                  if_req;
    logic [31:0]           if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [31:0]           if_rdata;
    logic                  d_req;
    logic                  d_we;
    logic [31:0]           d_addr;
    logic [31:0]           d_wdata;
    logic [3:0]            d_be;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [31:0]           d_rdata;
    logic                  mem_read_enable;
    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_addr_read;
    logic [ADDR_WIDTH-1:0] mem_addr_write;
    logic [31:0]           mem_data_in;
    logic [31:0]           mem_data_out;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_data_out,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_read_enable, mem_write_enable, mem_addr_read, mem_addr_write, mem_data_in
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_data_out,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_read_enable, mem_write_enable, mem_addr_read, mem_addr_write, mem_data_in
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Serializes instruction-fetch and load/store accesses onto one simple-dual-port BRAM,
// turning partial stores into read-modify-write sequences.
module bram_port_arbiter #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
) (
    input  logic                clock,
    input  logic                reset,
    bram_port_arbiter_if.slave  bus,
    output logic [1:0]          dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_WAIT   = 2'd1,
        RMW_MERGE = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    last_d_q;
    logic                    owner_q;
    logic [ADDR_WIDTH-1:0]   rmw_addr_q;
    logic [DATA_WIDTH-1:0]   rmw_wdata_q;
    logic [3:0]              rmw_be_q;

    logic [ADDR_WIDTH-1:0]   if_word;
    logic [ADDR_WIDTH-1:0]   d_word;
    logic                    idle_ok;
    logic                    if_win;
    logic                    if_gnt;
    logic                    d_gnt;
    logic                    d_full;
    logic                    d_part;
    logic                    in_rmw;
    logic                    in_rd;
    logic [DATA_WIDTH-1:0]   merged;
    logic                    unused_addr_bits;

    assign if_word = bus.if_addr[ADDR_WIDTH+1:2];
    assign d_word  = bus.d_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{bus.if_addr[31:ADDR_WIDTH+2], bus.if_addr[1:0],
                                bus.d_addr[31:ADDR_WIDTH+2], bus.d_addr[1:0]};

    // On conflict the requester that did not win last time goes first.
    assign if_win  = bus.if_req && (!bus.d_req || last_d_q);
    assign idle_ok = reset && (state_q == IDLE);
    assign if_gnt  = idle_ok && if_win;
    assign d_gnt   = idle_ok && bus.d_req && !if_win;
    assign d_full  = (bus.d_be == 4'b1111);
    assign d_part  = (bus.d_be != 4'b1111) && (bus.d_be != 4'b0000);
    assign in_rmw  = reset && (state_q == RMW_MERGE);
    assign in_rd   = reset && (state_q == RD_WAIT);

    always_comb begin
        merged = '0;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = rmw_be_q[i] ? rmw_wdata_q[8*i +: 8] : bus.mem_data_out[8*i +: 8];
        end
    end

    assign bus.if_gnt           = if_gnt;
    assign bus.d_gnt            = d_gnt;
    assign bus.mem_read_enable  = if_gnt || (d_gnt && (!bus.d_we || d_part));
    assign bus.mem_addr_read    = if_gnt ? if_word : d_word;
    assign bus.mem_write_enable = (d_gnt && bus.d_we && d_full) || in_rmw;
    assign bus.mem_addr_write   = in_rmw ? rmw_addr_q : d_word;
    assign bus.mem_data_in      = in_rmw ? merged : bus.d_wdata;

    // Read data comes straight from the BRAM output in the cycle after the read was issued.
    assign bus.if_rvalid = in_rd && !owner_q;
    assign bus.d_rvalid  = in_rd && owner_q;
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_data_out : '0;
    assign bus.d_rdata   = bus.d_rvalid ? bus.mem_data_out : '0;

    assign dbg_state_o = state_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            owner_q     <= 1'b0;
            rmw_addr_q  <= '0;
            rmw_wdata_q <= '0;
            rmw_be_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (if_gnt || d_gnt) begin
                        last_d_q <= d_gnt;
                    end
                    if (if_gnt) begin
                        owner_q <= 1'b0;
                        state_q <= RD_WAIT;
                    end else if (d_gnt && !bus.d_we) begin
                        owner_q <= 1'b1;
                        state_q <= RD_WAIT;
                    end else if (d_gnt && d_part) begin
                        rmw_addr_q  <= d_word;
                        rmw_wdata_q <= bus.d_wdata;
                        rmw_be_q    <= bus.d_be;
                        state_q     <= RMW_MERGE;
                    end
                end
                RD_WAIT:   state_q <= IDLE;
                RMW_MERGE: state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end
endmodule
